// File: rtl/cisc_prog_loader.sv
// Streams a program into instruction memory, reads it back to verify
// the checksum, then releases the CISC core from reset.
module cisc_prog_loader #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] checksum
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LASTIDX = CW'((1 << AW) - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, VERIFY, RUN, ERROR
  } state_t;

  state_t state, nxt;

  logic [CW-1:0] count;
  logic [CW-1:0] vidx;
  logic [DW-1:0] rbsum;
  logic          rd_a;
  logic          rd_d;
  logic          acc;
  logic          vfin;

  assign s_ready = (state == LOAD);
  assign acc     = s_valid && s_ready;
  // rd_a: address on the bus, rd_d: its data on mem_dout
  assign vfin    = (vidx == count) && !rd_a && !rd_d;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        if (acc) begin
          if (s_last)                nxt = VERIFY;
          else if (count == LASTIDX) nxt = ERROR;
        end
      end
      VERIFY: begin
        if (vfin)
          nxt = (rbsum == checksum) ? RUN : ERROR;
      end
      RUN:   if (start) nxt = LOAD;
      ERROR: if (start) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      vidx     <= '0;
      checksum <= '0;
      rbsum    <= '0;
      rd_a     <= 1'b0;
      rd_d     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      rd_a   <= 1'b0;
      rd_d   <= 1'b0;
      unique case (state)
        LOAD: begin
          if (acc) begin
            mem_we   <= 1'b1;
            mem_addr <= count[AW-1:0];
            mem_din  <= s_data;
            count    <= count + CW'(1);
            checksum <= checksum + s_data;
            if (nxt == ERROR) err <= 1'b1;
          end
        end
        VERIFY: begin
          if (vidx != count) begin
            mem_addr <= vidx[AW-1:0];
            vidx     <= vidx + CW'(1);
            rd_a     <= 1'b1;
          end
          rd_d <= rd_a;
          if (rd_d) rbsum <= rbsum + mem_dout;
          if (vfin) begin
            if (rbsum == checksum) begin
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            count    <= '0;
            vidx     <= '0;
            checksum <= '0;
            rbsum    <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cisc_prog_loader.sv
// Randomized scoreboard bench for cisc_prog_loader with a
// behavioural instruction-memory model.
module tb_cisc_prog_loader;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic          s_ready, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          core_rst, done, err;
  logic [DW-1:0] checksum;

  cisc_prog_loader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .core_rst(core_rst), .done(done), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // memory model; optionally corrupts bit 0 of the word stored at addr 5
  logic [DW-1:0] mem [32];
  logic          corrupt5;
  always @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= (corrupt5 && mem_addr == 5'd5) ?
                       (mem_din ^ 16'h0001) : mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct { int a; int d; } wr_t;
  wr_t exq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %0d data %0h got write expected none",
                 mem_addr, mem_din);
      end else begin
        wr_t e;
        e = exq.pop_front();
        chk("wr_addr", int'(mem_addr), e.a);
        chk("wr_data", int'(mem_din), e.d);
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_s_ready"}, int'(s_ready), 0);
    chk({nm, "_mem_we"}, int'(mem_we), 0);
    chk({nm, "_mem_addr"}, int'(mem_addr), 0);
    chk({nm, "_mem_din"}, int'(mem_din), 0);
    chk({nm, "_core_rst"}, int'(core_rst), 1);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_checksum"}, int'(checksum), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_core_rst", int'(core_rst), 1);
    chk("start_done", int'(done), 0);
    chk("start_err", int'(err), 0);
    chk("start_s_ready", int'(s_ready), 1);
    chk("start_checksum", int'(checksum), 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last,
                      input int idx, input int gap);
    repeat (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    exq.push_back('{a: idx, d: int'(d)});
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end(input bit ok, input logic [DW-1:0] ck,
                          input string nm);
    int n = 0;
    while (!done && !err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, int'(n < 300), 1);
    @(negedge clk);
    chk({nm, "_done"}, int'(done), int'(ok));
    chk({nm, "_err"}, int'(err), int'(!ok));
    chk({nm, "_core_rst"}, int'(core_rst), int'(!ok));
    chk({nm, "_checksum"}, int'(checksum), int'(ck));
    chk({nm, "_drain"}, exq.size(), 0);
  endtask

  // reference: checksum is the plain sum of the words; load succeeds only
  // when terminated by s_last and every read-back word matches
  task automatic run_load(input logic [DW-1:0] w[$], input bit lastflag,
                          input bit corrupt, input bit toggle,
                          input string nm);
    logic [DW-1:0] sum;
    bit ok;
    sum = '0;
    corrupt5 = corrupt;
    do_start();
    foreach (w[i]) begin
      sum += w[i];
      send(w[i], lastflag && (i == w.size() - 1), i,
           toggle ? int'(i > 0) : int'($urandom_range(0, 2)));
    end
    ok = lastflag && !(corrupt && w.size() > 5);
    wait_end(ok, sum, nm);
  endtask

  logic [DW-1:0] prog[$];
  logic [DW-1:0] wl[$];

  initial begin
    prog = '{16'h4497, 16'h0047, 16'h44D7, 16'h248F,
             16'h24CF, 16'h04E8, 16'h0001, 16'h6419,
             16'h601A, 16'h0047, 16'h234F, 16'h230F,
             16'h188C, 16'h1CCD, 16'h08C2, 16'h1083};
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    corrupt5 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    run_load(prog, 1'b1, 1'b0, 1'b0, "prog_ok");
    run_load(prog, 1'b1, 1'b1, 1'b0, "prog_corrupt");

    wl.delete();
    for (int i = 0; i < 32; i++) wl.push_back(DW'($urandom));
    run_load(wl, 1'b0, 1'b0, 1'b0, "overflow");
    s_valid = 1'b1;
    s_data = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("ovf_s_ready", int'(s_ready), 0);
    end
    s_valid = 1'b0;

    wl.delete();
    for (int i = 0; i < 32; i++) wl.push_back(DW'($urandom));
    run_load(wl, 1'b1, 1'b0, 1'b0, "full32_last");

    wl.delete();
    for (int i = 0; i < 4; i++) wl.push_back(DW'($urandom));
    run_load(wl, 1'b1, 1'b0, 1'b1, "toggle4");

    do_start();
    for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0, i, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    chk("midrst_drain", exq.size(), 0);
    repeat (2) @(negedge clk);
    wl.delete();
    for (int i = 0; i < 2; i++) wl.push_back(DW'($urandom));
    run_load(wl, 1'b1, 1'b0, 1'b0, "after_rst");

    chk("run_done_before_restart", int'(done), 1);
    wl.delete();
    for (int i = 0; i < 7; i++) wl.push_back(DW'($urandom));
    run_load(wl, 1'b1, 1'b0, 1'b0, "restart_from_run");

    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 32);
      wl.delete();
      for (int i = 0; i < n; i++) wl.push_back(DW'($urandom));
      run_load(wl, (n < 32) || ($urandom_range(0, 1) == 1),
               $urandom_range(0, 2) == 0, 1'b0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
